// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared histogram widths and readout state encoding
package hist_pkg;

    localparam int HIST_ADDR_WIDTH = 8;
    localparam int HIST_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_CAPT = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } hist_rd_state_e;

endpackage

// File: rtl/hist_sat_add.sv
// rtl/hist_sat_add.sv - unsigned saturating adder, clamps to all-ones of the result width
module hist_sat_add #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32,
    parameter int R_WIDTH = 32
) (
    input  logic [A_WIDTH-1:0] i_a,
    input  logic [B_WIDTH-1:0] i_b,
    output logic [R_WIDTH-1:0] o_sum
);

    localparam int MAX_AB  = (A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH;
    // One guard bit above the widest operand so the carry is never lost.
    localparam int S_WIDTH = ((MAX_AB > R_WIDTH) ? MAX_AB : R_WIDTH) + 1;

    logic [S_WIDTH-1:0] w_sum;

    assign w_sum = S_WIDTH'(i_a) + S_WIDTH'(i_b);
    assign o_sum = (|w_sum[S_WIDTH-1:R_WIDTH]) ? {R_WIDTH{1'b1}} : w_sum[R_WIDTH-1:0];

endmodule

// File: rtl/hist_readout.sv
// rtl/hist_readout.sv - scans histogram RAM port B, emits bin/count/CDF beats, optionally clears bins
module hist_readout
    import hist_pkg::*;
#(
    parameter int ADDR_WIDTH = HIST_ADDR_WIDTH,
    parameter int DATA_WIDTH = HIST_DATA_WIDTH,
    parameter int CDF_WIDTH  = 32,
    parameter int CLEAR_EN   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wr_data,
    output logic                  o_ram_wr_en,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [ADDR_WIDTH-1:0] o_m_bin,
    output logic [DATA_WIDTH-1:0] o_m_count,
    output logic [CDF_WIDTH-1:0]  o_m_cdf,
    output logic                  o_m_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_BIN = {ADDR_WIDTH{1'b1}};

    hist_rd_state_e        r_state;
    logic [ADDR_WIDTH-1:0] r_n;
    logic [CDF_WIDTH-1:0]  r_acc;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wr_en;
    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_bin;
    logic [DATA_WIDTH-1:0] r_count;
    logic [CDF_WIDTH-1:0]  r_cdf;
    logic                  r_last;
    logic [CDF_WIDTH-1:0]  w_acc_next;

    hist_sat_add #(
        .A_WIDTH(CDF_WIDTH),
        .B_WIDTH(DATA_WIDTH),
        .R_WIDTH(CDF_WIDTH)
    ) u_sat_add (
        .i_a  (r_acc),
        .i_b  (i_ram_rd_data),
        .o_sum(w_acc_next)
    );

    // The bin counter doubles as the port B address for both the read and the clear write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            r_valid <= 1'b0;
            r_bin   <= '0;
            r_count <= '0;
            r_cdf   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_n     <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_state <= ST_CAPT;
                end
                ST_CAPT: begin
                    r_count <= i_ram_rd_data;
                    r_cdf   <= w_acc_next;
                    r_acc   <= w_acc_next;
                    r_bin   <= r_n;
                    r_last  <= (r_n == LAST_BIN);
                    r_valid <= 1'b1;
                    // Clear pulse lives only in the first OUT cycle, so stalls never repeat it.
                    r_wr_en <= (CLEAR_EN != 0);
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    if (i_m_ready) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_n     <= r_n + 1'b1;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_ram_addr    = r_n;
    assign o_ram_wr_data = '0;
    assign o_ram_wr_en   = r_wr_en;
    assign o_m_valid     = r_valid;
    assign o_m_bin       = r_bin;
    assign o_m_count     = r_count;
    assign o_m_cdf       = r_cdf;
    assign o_m_last      = r_last;

endmodule

// File: tb/tb_hist_readout.sv
// tb/tb_hist_readout.sv - randomized self-checking bench for hist_readout against an arithmetic CDF model
module tb_hist_readout;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int NBIN = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_c = 1'b0;
    logic start_n = 1'b0;
    logic m_ready = 1'b0;
    logic load_c = 1'b0;
    logic load_n = 1'b0;
    logic sel = 1'b0;

    logic          c_busy, c_done, c_we, c_valid, c_last;
    logic [AW-1:0] c_addr, c_bin;
    logic [DW-1:0] c_wd, c_count, c_cdf, rd_c;
    logic          n_busy, n_done, n_we, n_valid, n_last;
    logic [AW-1:0] n_addr, n_bin;
    logic [DW-1:0] n_wd, n_count, n_cdf, rd_n;

    logic [DW-1:0] mem_c [NBIN];
    logic [DW-1:0] mem_n [NBIN];
    logic [DW-1:0] img   [NBIN];
    logic [DW-1:0] exp_cdf [NBIN];

    int n_tests = 0;
    int n_fail  = 0;

    int            q_bin [$];
    logic [DW-1:0] q_count [$];
    logic [DW-1:0] q_cdf [$];
    bit            q_last [$];
    int first_valid, last_hs, done_cyc, busy_low, wr_cnt, stab_err;
    bit timed_out;
    int wr_hits [NBIN];

    always #5 clk = ~clk;

    hist_readout #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CDF_WIDTH(32), .CLEAR_EN(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start_c), .o_busy(c_busy), .o_done(c_done),
        .o_ram_addr(c_addr), .o_ram_wr_data(c_wd), .o_ram_wr_en(c_we), .i_ram_rd_data(rd_c),
        .o_m_valid(c_valid), .i_m_ready(m_ready), .o_m_bin(c_bin), .o_m_count(c_count),
        .o_m_cdf(c_cdf), .o_m_last(c_last)
    );

    hist_readout #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CDF_WIDTH(32), .CLEAR_EN(0)) dut_nc (
        .i_clk(clk), .i_rst(rst), .i_start(start_n), .o_busy(n_busy), .o_done(n_done),
        .o_ram_addr(n_addr), .o_ram_wr_data(n_wd), .o_ram_wr_en(n_we), .i_ram_rd_data(rd_n),
        .o_m_valid(n_valid), .i_m_ready(m_ready), .o_m_bin(n_bin), .o_m_count(n_count),
        .o_m_cdf(n_cdf), .o_m_last(n_last)
    );

    always @(posedge clk) begin
        if (load_c) begin
            for (int i = 0; i < NBIN; i++) mem_c[i] <= img[i];
        end else begin
            rd_c <= mem_c[c_addr];
            if (c_we) mem_c[c_addr] <= c_wd;
        end
    end

    always @(posedge clk) begin
        if (load_n) begin
            for (int i = 0; i < NBIN; i++) mem_n[i] <= img[i];
        end else begin
            rd_n <= mem_n[n_addr];
            if (n_we) mem_n[n_addr] <= n_wd;
        end
    end

    logic          w_busy, w_done, w_we, w_valid, w_last;
    logic [AW-1:0] w_addr, w_bin;
    logic [DW-1:0] w_count, w_cdf;
    assign w_busy  = sel ? n_busy  : c_busy;
    assign w_done  = sel ? n_done  : c_done;
    assign w_we    = sel ? n_we    : c_we;
    assign w_valid = sel ? n_valid : c_valid;
    assign w_last  = sel ? n_last  : c_last;
    assign w_addr  = sel ? n_addr  : c_addr;
    assign w_bin   = sel ? n_bin   : c_bin;
    assign w_count = sel ? n_count : c_count;
    assign w_cdf   = sel ? n_cdf   : c_cdf;

    // Reference CDF: running sum in 64-bit arithmetic, clamped to the 32-bit maximum.
    task automatic build_model();
        logic [63:0] acc;
        acc = 64'd0;
        for (int i = 0; i < NBIN; i++) begin
            acc = acc + {32'd0, img[i]};
            if (acc > 64'h0000_0000_FFFF_FFFF) acc = 64'h0000_0000_FFFF_FFFF;
            exp_cdf[i] = acc[31:0];
        end
    endtask

    task automatic load_ram(input bit which);
        @(negedge clk);
        if (which) load_n = 1'b1; else load_c = 1'b1;
        @(negedge clk);
        load_n = 1'b0;
        load_c = 1'b0;
    endtask

    // Runs one scan on the selected instance and records beats, timing and write activity.
    task automatic do_scan(input int pct);
        int rel;
        bit stalled;
        logic [AW-1:0] s_bin;
        logic [DW-1:0] s_cnt, s_cdf;
        logic s_last;
        q_bin.delete(); q_count.delete(); q_cdf.delete(); q_last.delete();
        first_valid = -1; last_hs = -1; done_cyc = -1; busy_low = -1;
        wr_cnt = 0; stab_err = 0; timed_out = 1'b0; stalled = 1'b0;
        s_bin = '0; s_cnt = '0; s_cdf = '0; s_last = 1'b0;
        for (int i = 0; i < NBIN; i++) wr_hits[i] = 0;
        @(negedge clk);
        if (sel) start_n = 1'b1; else start_c = 1'b1;
        m_ready = 1'b1;
        rel = 0;
        while (busy_low < 0 && !timed_out) begin
            @(negedge clk);
            rel++;
            start_c = 1'b0;
            start_n = 1'b0;
            if (rel > 20000) timed_out = 1'b1;
            if (stalled && (w_valid !== 1'b1 || w_bin !== s_bin || w_count !== s_cnt ||
                            w_cdf !== s_cdf || w_last !== s_last)) stab_err++;
            if (w_we === 1'b1) begin
                wr_cnt++;
                wr_hits[w_addr]++;
            end
            if (w_done === 1'b1 && done_cyc < 0) done_cyc = rel;
            if (w_busy === 1'b0) busy_low = rel;
            m_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            if (w_valid === 1'b1) begin
                if (first_valid < 0) first_valid = rel;
                if (m_ready) begin
                    q_bin.push_back(int'(w_bin));
                    q_count.push_back(w_count);
                    q_cdf.push_back(w_cdf);
                    q_last.push_back(w_last);
                    last_hs = rel;
                end
            end
            stalled = (w_valid === 1'b1) && !m_ready;
            s_bin = w_bin; s_cnt = w_count; s_cdf = w_cdf; s_last = w_last;
        end
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (c_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b want=0", c_busy); end
        n_tests++; if (c_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b want=0", c_done); end
        n_tests++; if (c_addr !== '0) begin n_fail++; $display("FAIL reset_ram_addr got=%0h want=0", c_addr); end
        n_tests++; if (c_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_wr_en got=%0b want=0", c_we); end
        n_tests++; if (c_wd !== '0) begin n_fail++; $display("FAIL reset_ram_wr_data got=%0h want=0", c_wd); end
        n_tests++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%0b want=0", c_valid); end
        n_tests++; if (c_bin !== '0) begin n_fail++; $display("FAIL reset_m_bin got=%0h want=0", c_bin); end
        n_tests++; if (c_count !== '0) begin n_fail++; $display("FAIL reset_m_count got=%0h want=0", c_count); end
        n_tests++; if (c_cdf !== '0) begin n_fail++; $display("FAIL reset_m_cdf got=%0h want=0", c_cdf); end
        n_tests++; if (c_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got=%0b want=0", c_last); end
    endtask

    task automatic test_full_scan();
        int nz;
        sel = 1'b0;
        for (int i = 0; i < NBIN; i++) img[i] = DW'(i);
        load_ram(1'b0);
        do_scan(100);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL full_timeout got=timeout want=finish"); end
        n_tests++; if (q_bin.size() != NBIN) begin n_fail++; $display("FAIL full_beats got=%0d want=%0d", q_bin.size(), NBIN); end
        for (int i = 0; i < q_bin.size() && i < NBIN; i++) begin
            n_tests++;
            if (q_bin[i] != i || q_count[i] !== DW'(i) || q_cdf[i] !== DW'(i * (i + 1) / 2) || q_last[i] !== (i == NBIN - 1)) begin
                n_fail++;
                $display("FAIL full_beat%0d got bin=%0d cnt=%0d cdf=%0d last=%0b want bin=%0d cnt=%0d cdf=%0d last=%0b",
                         i, q_bin[i], q_count[i], q_cdf[i], q_last[i], i, i, i * (i + 1) / 2, i == NBIN - 1);
            end
        end
        if (q_cdf.size() == NBIN) begin
            n_tests++; if (q_cdf[NBIN-1] !== 32'd32640) begin n_fail++; $display("FAIL full_last_cdf got=%0d want=32640", q_cdf[NBIN-1]); end
        end
        n_tests++; if (first_valid != 3) begin n_fail++; $display("FAIL full_first_valid got=%0d want=3", first_valid); end
        n_tests++; if (last_hs != 768) begin n_fail++; $display("FAIL full_last_handshake got=%0d want=768", last_hs); end
        n_tests++; if (done_cyc != 769) begin n_fail++; $display("FAIL full_done_cycle got=%0d want=769", done_cyc); end
        n_tests++; if (busy_low != 770) begin n_fail++; $display("FAIL full_busy_low got=%0d want=770", busy_low); end
        nz = 0;
        for (int i = 0; i < NBIN; i++) if (mem_c[i] !== '0) nz++;
        n_tests++; if (nz != 0) begin n_fail++; $display("FAIL full_ram_cleared got=%0d nonzero want=0", nz); end
    endtask

    task automatic test_backpressure();
        int nz, bad_hits;
        sel = 1'b0;
        for (int i = 0; i < NBIN; i++) img[i] = $urandom() & 32'h000F_FFFF;
        build_model();
        load_ram(1'b0);
        do_scan(30);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout got=timeout want=finish"); end
        n_tests++; if (q_bin.size() != NBIN) begin n_fail++; $display("FAIL bp_beats got=%0d want=%0d", q_bin.size(), NBIN); end
        for (int i = 0; i < q_bin.size() && i < NBIN; i++) begin
            n_tests++;
            if (q_bin[i] != i || q_count[i] !== img[i] || q_cdf[i] !== exp_cdf[i] || q_last[i] !== (i == NBIN - 1)) begin
                n_fail++;
                $display("FAIL bp_beat%0d got bin=%0d cnt=%0h cdf=%0h want bin=%0d cnt=%0h cdf=%0h",
                         i, q_bin[i], q_count[i], q_cdf[i], i, img[i], exp_cdf[i]);
            end
        end
        n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_stall_stable got=%0d changes want=0", stab_err); end
        n_tests++; if (wr_cnt != NBIN) begin n_fail++; $display("FAIL bp_wr_pulses got=%0d want=%0d", wr_cnt, NBIN); end
        bad_hits = 0;
        for (int i = 0; i < NBIN; i++) if (wr_hits[i] != 1) bad_hits++;
        n_tests++; if (bad_hits != 0) begin n_fail++; $display("FAIL bp_wr_per_addr got=%0d bad addrs want=0", bad_hits); end
        nz = 0;
        for (int i = 0; i < NBIN; i++) if (mem_c[i] !== '0) nz++;
        n_tests++; if (nz != 0) begin n_fail++; $display("FAIL bp_ram_cleared got=%0d nonzero want=0", nz); end
    endtask

    task automatic test_saturation();
        int bad;
        sel = 1'b0;
        img[0] = 32'hFFFF_FFF0;
        img[1] = 32'h0000_0020;
        for (int i = 2; i < NBIN; i++) img[i] = 32'd1;
        load_ram(1'b0);
        do_scan(100);
        n_tests++; if (q_cdf.size() != NBIN) begin n_fail++; $display("FAIL sat_beats got=%0d want=%0d", q_cdf.size(), NBIN); end
        if (q_cdf.size() == NBIN) begin
            n_tests++; if (q_cdf[0] !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL sat_bin0 got=%0h want=fffffff0", q_cdf[0]); end
            bad = 0;
            for (int i = 1; i < NBIN; i++) if (q_cdf[i] !== 32'hFFFF_FFFF) bad++;
            n_tests++; if (bad != 0) begin n_fail++; $display("FAIL sat_clamped got=%0d unclamped bins want=0", bad); end
        end
    endtask

    task automatic test_no_clear();
        logic [DW-1:0] first_cdf [NBIN];
        logic [DW-1:0] first_cnt [NBIN];
        int diff;
        sel = 1'b1;
        for (int i = 0; i < NBIN; i++) img[i] = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'h0000_FFFF);
        build_model();
        load_ram(1'b1);
        do_scan(50);
        n_tests++; if (q_bin.size() != NBIN) begin n_fail++; $display("FAIL nc_beats got=%0d want=%0d", q_bin.size(), NBIN); end
        for (int i = 0; i < q_bin.size() && i < NBIN; i++) begin
            n_tests++;
            if (q_bin[i] != i || q_count[i] !== img[i] || q_cdf[i] !== exp_cdf[i]) begin
                n_fail++;
                $display("FAIL nc_beat%0d got cnt=%0h cdf=%0h want cnt=%0h cdf=%0h", i, q_count[i], q_cdf[i], img[i], exp_cdf[i]);
            end
            first_cdf[i] = q_cdf[i];
            first_cnt[i] = q_count[i];
        end
        n_tests++; if (wr_cnt != 0) begin n_fail++; $display("FAIL nc_wr_en got=%0d pulses want=0", wr_cnt); end
        diff = 0;
        for (int i = 0; i < NBIN; i++) if (mem_n[i] !== img[i]) diff++;
        n_tests++; if (diff != 0) begin n_fail++; $display("FAIL nc_ram_intact got=%0d changed want=0", diff); end
        do_scan(100);
        diff = (q_bin.size() == NBIN) ? 0 : 1;
        for (int i = 0; i < q_bin.size() && i < NBIN; i++)
            if (q_cdf[i] !== first_cdf[i] || q_count[i] !== first_cnt[i]) diff++;
        n_tests++; if (diff != 0) begin n_fail++; $display("FAIL nc_second_scan got=%0d differences want=0", diff); end
        sel = 1'b0;
    endtask

    task automatic test_start_corners();
        int rel, expect_bin, order_err, nbad;
        bit poked, just_poked, hit100;
        sel = 1'b0;
        for (int i = 0; i < NBIN; i++) img[i] = $urandom() & 32'h00FF_FFFF;
        load_ram(1'b0);
        @(negedge clk);
        start_c = 1'b1;
        m_ready = 1'b1;
        rel = 0; expect_bin = 0; order_err = 0;
        poked = 1'b0; just_poked = 1'b0; hit100 = 1'b0;
        while (!hit100 && rel < 2000) begin
            @(negedge clk);
            rel++;
            start_c = 1'b0;
            if (just_poked) begin
                just_poked = 1'b0;
                n_tests++;
                if (c_valid !== 1'b1 || c_bin !== 8'd7 || c_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_in_out got valid=%0b bin=%0d busy=%0b want valid=1 bin=7 busy=1", c_valid, c_bin, c_busy);
                end
            end
            m_ready = 1'b1;
            if (c_valid === 1'b1) begin
                if (c_bin === 8'd100) begin
                    hit100 = 1'b1;
                    m_ready = 1'b0;
                end else if (c_bin === 8'd7 && !poked) begin
                    poked = 1'b1;
                    just_poked = 1'b1;
                    start_c = 1'b1;
                    m_ready = 1'b0;
                end else begin
                    if (int'(c_bin) != expect_bin) order_err++;
                    expect_bin++;
                end
            end
        end
        n_tests++; if (!hit100 || order_err != 0 || expect_bin != 100) begin
            n_fail++; $display("FAIL corner_sequence got reached=%0b order_err=%0d beats=%0d want reached=1 order_err=0 beats=100", hit100, order_err, expect_bin);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if ({c_busy, c_done, c_we, c_valid, c_last} !== 5'b0 || c_addr !== '0 || c_bin !== '0 || c_count !== '0 || c_cdf !== '0) begin
            n_fail++; $display("FAIL midscan_reset got busy=%0b valid=%0b we=%0b addr=%0d bin=%0d cdf=%0h want all 0", c_busy, c_valid, c_we, c_addr, c_bin, c_cdf);
        end
        rst = 1'b0;
        @(negedge clk);
        nbad = 0;
        for (int i = 0; i <= 100; i++) if (mem_c[i] !== '0) nbad++;
        n_tests++; if (nbad != 0) begin n_fail++; $display("FAIL reset_cleared_bins got=%0d nonzero want=0", nbad); end
        nbad = 0;
        for (int i = 101; i < NBIN; i++) if (mem_c[i] !== img[i]) nbad++;
        n_tests++; if (nbad != 0) begin n_fail++; $display("FAIL reset_intact_bins got=%0d changed want=0", nbad); end
        for (int i = 0; i <= 100; i++) img[i] = '0;
        build_model();
        do_scan(100);
        n_tests++; if (q_bin.size() != NBIN) begin n_fail++; $display("FAIL restart_beats got=%0d want=%0d", q_bin.size(), NBIN); end
        nbad = 0;
        for (int i = 0; i < q_bin.size() && i < NBIN; i++)
            if (q_bin[i] != i || q_count[i] !== img[i] || q_cdf[i] !== exp_cdf[i]) nbad++;
        n_tests++; if (nbad != 0) begin n_fail++; $display("FAIL restart_model got=%0d bad beats want=0", nbad); end
        if (q_bin.size() > 0) begin
            n_tests++; if (q_bin[0] != 0 || q_cdf[0] !== '0) begin
                n_fail++; $display("FAIL restart_origin got bin=%0d cdf=%0h want bin=0 cdf=0", q_bin[0], q_cdf[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_backpressure();
        test_saturation();
        test_no_clear();
        test_start_corners();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hist_readout.md
# hist_readout

Reads out the 256-bin luminance histogram after each frame and optionally clears it for the next frame. It sits on port B of the histogram dual-port RAM, opposite the pixel accumulator that does read-modify-write on port A. Each bin is emitted as a valid/ready beat carrying the bin index, the raw count and a running cumulative sum (CDF) for the equalization stage.

## Interface
Parameters:
- ADDR_WIDTH, 8: bin address width; the block scans 2^ADDR_WIDTH bins.
- DATA_WIDTH, 32: bin count width, matching the RAM data width.
- CDF_WIDTH, 32: cumulative-sum width; saturates at all-ones.
- CLEAR_EN, 1: 1 writes zero back to each bin after it is read; 0 leaves the RAM untouched.

Ports:
- clk  in  1  single clock; RAM port B is clocked by the same clk.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle scan request; honoured only in IDLE.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.
- ram_addr  out  ADDR_WIDTH  port B address.
- ram_wr_data  out  DATA_WIDTH  port B write data; always 0.
- ram_wr_en  out  1  port B write enable.
- ram_rd_data  in  DATA_WIDTH  port B read data; valid 1 cycle after the address (no output register).
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_bin  out  ADDR_WIDTH  bin index.
- m_count  out  DATA_WIDTH  bin count.
- m_cdf  out  CDF_WIDTH  saturating sum of counts for bins 0..m_bin inclusive.
- m_last  out  1  high on the beat for bin 2^ADDR_WIDTH-1.

## Operation
- FSM states: IDLE, READ, CAPT, OUT, DONE.
- IDLE: start=1 clears the bin counter and CDF accumulator to 0, then goes to READ.
- READ: drives ram_addr=n with ram_wr_en=0, then goes to CAPT.
- CAPT:
  - m_count <= ram_rd_data.
  - m_cdf <= sat(acc + ram_rd_data), and acc is updated to the same value.
  - m_bin <= n.
  - Goes to OUT.
- OUT:
  - m_valid=1.
  - On the first OUT cycle only, if CLEAR_EN: ram_wr_en=1 and ram_wr_data=0 at ram_addr=n.
  - On m_valid&&m_ready: if n is the last bin, go to DONE; otherwise n++ and go to READ.
- DONE: done=1 for one cycle, then go to IDLE.
- Arithmetic: the CDF adds the zero-extended count. On overflow it clamps to 2^CDF_WIDTH-1 and stays clamped for the rest of the scan.
- Stalls: m_bin, m_count, m_cdf and m_last stay stable while m_valid && !m_ready. The clear write is issued exactly once per bin, regardless of stall length.
- start is ignored in READ, CAPT, OUT and DONE. A start asserted during DONE is lost.
- rst mid-scan returns the block to IDLE. Bins already cleared stay cleared, and the remainder keep their counts. The host must issue a new start.
- The RAM port A accumulator must be quiescent (vertical blanking) during a scan. This block does not arbitrate.

## Timing
- Reset values: every output is 0, including ram_addr, ram_wr_en, m_valid, busy and done.
- Start sampled in cycle 0 gives:
  - READ at cycle 1, CAPT at 2, first m_valid at 3.
  - With m_ready=1, one beat every 3 cycles.
- Full scan with 256 bins and m_ready held high:
  - Last handshake at cycle 768.
  - done=1 at cycle 769.
  - busy high over cycles 1..769, low at 770.
- Read latency is fixed at 1 cycle. CAPT samples ram_rd_data exactly 1 cycle after READ.

## Structure
- Shared package hist_pkg holds:
  - HIST_ADDR_WIDTH=8 and HIST_DATA_WIDTH=32, shared with the accumulator and the RAM wrapper.
  - The hist_readout state enum.
- One sub-module is natural: hist_sat_add, a parameterised saturating adder (widths A, B, result). The accumulator reuses it for saturating bin increments.

## Test plan
- Full scan: preload bin[i]=i, m_ready=1, start.
  - Required: 256 beats with m_bin 0..255, m_count=i, m_cdf=i(i+1)/2.
  - m_last only on bin 255, with m_cdf=32640.
  - Timing exactly as specified (first m_valid at cycle 3, done at cycle 769).
  - RAM all zero afterwards.
- Backpressure: random m_ready at 30% duty.
  - Required: no dropped or duplicated beats, and outputs stable while stalled.
  - Exactly 256 ram_wr_en pulses, one per address.
- Saturation: bin0=0xFFFF_FFF0, bin1=0x20, remaining bins=1.
  - Required: m_cdf(bin0)=0xFFFF_FFF0.
  - m_cdf(bin1) and all later bins = 0xFFFF_FFFF.
- CLEAR_EN=0: full scan of random contents.
  - Required: ram_wr_en never asserted and RAM contents unchanged.
  - Second scan output identical to the first.
- Start/reset corners:
  - start pulsed during OUT: no effect.
  - rst asserted while m_bin=100: next cycle all outputs 0 and busy=0; bins 0..100 are zero and bins 101..255 are intact.
  - Fresh start: scan restarts at bin 0 with m_cdf from 0.
